// File: rtl/audio_csr_bank.sv
// rtl/audio_csr_bank.sv - AudioNet control/status register bank (TDM2P, P2TDM, gain/balance, TDM mux)
// Optional feature: define CSR_CLR_ON_READ_EN to clear the error counters when 0x104 is read.
module audio_csr_bank #(
  parameter int N_CH    = 4,
  parameter int PDATA_W = 256,
  parameter int GAIN_W  = 16,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     val,
  input  logic [9:0]               addr,
  input  logic                     write,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     err,
  output logic                     tdm2p_en,
  output logic [7:0]               tdm2p_clk_mask,
  output logic [7:0]               tdm2p_clk_patt,
  input  logic                     tdm2p_valid,
  input  logic [PDATA_W-1:0]       tdm2p_pdata,
  output logic                     p2tdm_en,
  input  logic                     p2tdm_retrans_incr,
  input  logic                     p2tdm_dropped_incr,
  output logic                     p2tdm_valid,
  output logic [PDATA_W-1:0]       p2tdm_pdata,
  output logic [N_CH*GAIN_W-1:0]   gain,
  output logic [N_CH*8-1:0]        bal,
  output logic                     sel,
  output logic                     irq
);

  localparam int NW        = PDATA_W / 32;
  localparam int W_CTRL    = 'h00;
  localparam int W_STAT    = 'h01;
  localparam int W_SNAP    = 'h04;
  localparam int W_P2EN    = 'h40;
  localparam int W_CNT     = 'h41;
  localparam int W_PKT     = 'h44;
  localparam int W_GAIN    = 'h80;
  localparam int W_SEL     = 'hC0;

  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_n;

  logic [7:0]        word;
  logic              acc, wr, rd;
  logic              irq_en, frame_new, ovf;
  logic [CNT_W-1:0]  retrans, dropped;
  logic [31:0]       snap [NW];
  logic [GAIN_W-1:0] gain_r [N_CH];
  logic [7:0]        bal_r [N_CH];
  logic [31:0]       rd_val;
  logic              hit, ro;
  logic              unused_addr;

  assign word        = addr[9:2];
  assign unused_addr = ^addr[1:0];
  assign acc         = (state == IDLE) && val;
  assign wr          = acc && write;
  assign rd          = acc && !write;
  assign irq         = frame_new & irq_en;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    ready   = 1'b0;
    case (state)
      IDLE: if (val) state_n = RESP;
      RESP: begin
        ready   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Read decode; ro marks mapped addresses that reject writes
  always_comb begin
    rd_val = 32'h0;
    hit    = 1'b0;
    ro     = 1'b0;
    if (word == 8'(W_CTRL)) begin
      hit    = 1'b1;
      rd_val = {tdm2p_en, irq_en, 14'h0, tdm2p_clk_mask, tdm2p_clk_patt};
    end
    if (word == 8'(W_STAT)) begin
      hit    = 1'b1;
      rd_val = {30'h0, ovf, frame_new};
    end
    for (int k = 0; k < NW; k++) begin
      if (word == 8'(W_SNAP + k)) begin
        hit    = 1'b1;
        ro     = 1'b1;
        rd_val = (k == 0) ? tdm2p_pdata[31:0] : snap[k];
      end
      if (word == 8'(W_PKT + k)) begin
        hit    = 1'b1;
        rd_val = p2tdm_pdata[k*32 +: 32];
      end
    end
    if (word == 8'(W_P2EN)) begin
      hit    = 1'b1;
      rd_val = {p2tdm_en, 31'h0};
    end
    if (word == 8'(W_CNT)) begin
      hit    = 1'b1;
      rd_val = {16'(retrans), 16'(dropped)};
    end
    for (int c = 0; c < N_CH; c++) begin
      if (word == 8'(W_GAIN + c)) begin
        hit    = 1'b1;
        rd_val = {8'h0, bal_r[c], 16'(gain_r[c])};
      end
    end
    if (word == 8'(W_SEL)) begin
      hit    = 1'b1;
      rd_val = {31'h0, sel};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata          <= 32'h0;
      err            <= 1'b0;
      tdm2p_en       <= 1'b0;
      irq_en         <= 1'b0;
      tdm2p_clk_mask <= 8'h0;
      tdm2p_clk_patt <= 8'h0;
      frame_new      <= 1'b0;
      ovf            <= 1'b0;
      p2tdm_en       <= 1'b0;
      p2tdm_valid    <= 1'b0;
      p2tdm_pdata    <= '0;
      retrans        <= '0;
      dropped        <= '0;
      sel            <= 1'b0;
      for (int k = 0; k < NW; k++) snap[k] <= 32'h0;
      for (int c = 0; c < N_CH; c++) begin
        gain_r[c] <= '0;
        bal_r[c]  <= 8'h0;
      end
    end else begin
      p2tdm_valid <= 1'b0;
      if (acc) begin
        rdata <= write ? wdata : (hit ? rd_val : 32'hBADACE55);
        err   <= write ? !(hit && !ro) : !hit;
      end

      // A new packet always wins over the word-0 read that consumes the old one
      if (tdm2p_valid)                         frame_new <= 1'b1;
      else if (rd && word == 8'(W_SNAP))       frame_new <= 1'b0;
      if (tdm2p_valid && frame_new)            ovf <= 1'b1;
      else if (wr && word == 8'(W_STAT) && wdata[1]) ovf <= 1'b0;

      if (rd && word == 8'(W_SNAP))
        for (int k = 0; k < NW; k++) snap[k] <= tdm2p_pdata[k*32 +: 32];

      if (wr && word == 8'(W_CNT)) begin
        retrans <= wdata[16 +: CNT_W];
        dropped <= wdata[CNT_W-1:0];
      end
`ifdef CSR_CLR_ON_READ_EN
      else if (rd && word == 8'(W_CNT)) begin
        retrans <= CNT_W'(p2tdm_retrans_incr);
        dropped <= CNT_W'(p2tdm_dropped_incr);
      end
`endif
      else begin
        if (p2tdm_retrans_incr && !(&retrans)) retrans <= retrans + CNT_W'(1);
        if (p2tdm_dropped_incr && !(&dropped)) dropped <= dropped + CNT_W'(1);
      end

      if (wr) begin
        if (word == 8'(W_CTRL)) begin
          tdm2p_en       <= wdata[31];
          irq_en         <= wdata[30];
          tdm2p_clk_mask <= wdata[15:8];
          tdm2p_clk_patt <= wdata[7:0];
        end
        if (word == 8'(W_P2EN)) p2tdm_en <= wdata[31];
        if (word == 8'(W_SEL))  sel      <= wdata[0];
        for (int k = 0; k < NW; k++) begin
          if (word == 8'(W_PKT + k)) begin
            p2tdm_pdata[k*32 +: 32] <= wdata;
            if (k == NW - 1) p2tdm_valid <= 1'b1;
          end
        end
        for (int c = 0; c < N_CH; c++) begin
          if (word == 8'(W_GAIN + c)) begin
            gain_r[c] <= wdata[GAIN_W-1:0];
            bal_r[c]  <= wdata[23:16];
          end
        end
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign gain[c*GAIN_W +: GAIN_W] = gain_r[c];
    assign bal[c*8 +: 8]            = bal_r[c];
  end

endmodule

// File: tb/tb_audio_csr_bank.sv
// tb/tb_audio_csr_bank.sv - directed self-checking bench for audio_csr_bank (N_CH=8)
module tb_audio_csr_bank;
  localparam int N_CH = 8, PDATA_W = 256, GAIN_W = 16, CNT_W = 16;

  logic clk = 1'b0, rstn = 1'b0;
  logic val = 1'b0, write = 1'b0;
  logic [9:0] addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic ready, err, tdm2p_en, tdm2p_valid = 1'b0, p2tdm_en, p2tdm_valid, sel, irq;
  logic [7:0] tdm2p_clk_mask, tdm2p_clk_patt;
  logic [PDATA_W-1:0] tdm2p_pdata = '0, p2tdm_pdata, pkt_seen;
  logic p2tdm_retrans_incr = 1'b0, p2tdm_dropped_incr = 1'b0;
  logic [N_CH*GAIN_W-1:0] gain;
  logic [N_CH*8-1:0] bal;

  int checks = 0, errors = 0, pulses = 0, lat;
  logic pulse_with_ready;

  audio_csr_bank #(.N_CH(N_CH), .PDATA_W(PDATA_W), .GAIN_W(GAIN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .val(val), .addr(addr), .write(write), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .tdm2p_en(tdm2p_en),
    .tdm2p_clk_mask(tdm2p_clk_mask), .tdm2p_clk_patt(tdm2p_clk_patt),
    .tdm2p_valid(tdm2p_valid), .tdm2p_pdata(tdm2p_pdata), .p2tdm_en(p2tdm_en),
    .p2tdm_retrans_incr(p2tdm_retrans_incr), .p2tdm_dropped_incr(p2tdm_dropped_incr),
    .p2tdm_valid(p2tdm_valid), .p2tdm_pdata(p2tdm_pdata), .gain(gain), .bal(bal),
    .sel(sel), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (p2tdm_valid) begin
      pulses++;
      pkt_seen = p2tdm_pdata;
      pulse_with_ready = ready;
    end
  end

  task automatic bus(input logic [9:0] a, input logic w, input logic [31:0] d, input logic inc,
                     output logic [31:0] rd, output logic e);
    int n;
    @(negedge clk);
    val = 1'b1; addr = a; write = w; wdata = d; p2tdm_retrans_incr = inc;
    @(negedge clk);
    val = 1'b0; p2tdm_retrans_incr = 1'b0;
    n = 0;
    while (!ready && n < 8) begin @(negedge clk); n++; end
    lat = n;
    if (!ready) begin
      errors++; checks++;
      $display("FAIL bus_timeout addr=%h ready never rose", a);
    end
    rd = rdata; e = err;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] rd; logic e;
    if ({ready, err, rdata, irq, tdm2p_en, p2tdm_valid, sel} !== 38'h0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {ready, err, rdata, irq, tdm2p_en, p2tdm_valid, sel});
    end
    checks++;
    if (gain !== '0 || p2tdm_pdata !== '0) begin errors++; $display("FAIL reset_vectors got nonzero exp 0"); end
    checks++;
    bus(10'h000, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL rd_000 got %h/%b exp 0/0", rd, e); end
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL ready_latency got %0d exp 0", lat); end
    checks++;
    bus(10'h104, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL rd_104 got %h/%b exp 0/0", rd, e); end
    checks++;
    bus(10'h200, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL rd_200 got %h/%b exp 0/0", rd, e); end
    checks++;
  endtask

  task automatic test_unmapped;
    logic [31:0] rd; logic e;
    bus(10'h000, 1'b1, 32'h8000_A55A, 1'b0, rd, e);
    bus(10'h0F0, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'hBADACE55 || e !== 1'b1) begin errors++; $display("FAIL unmapped_rd got %h/%b exp badace55/1", rd, e); end
    checks++;
    bus(10'h0F0, 1'b1, 32'h1234_5678, 1'b0, rd, e);
    if (rd !== 32'h1234_5678 || e !== 1'b1) begin errors++; $display("FAIL unmapped_wr got %h/%b exp 12345678/1", rd, e); end
    checks++;
    bus(10'h014, 1'b1, 32'hFFFF_FFFF, 1'b0, rd, e);
    if (e !== 1'b1) begin errors++; $display("FAIL ro_wr_err got %b exp 1", e); end
    checks++;
    bus(10'h000, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'h8000_A55A || e !== 1'b0) begin errors++; $display("FAIL ctrl_kept got %h/%b exp 8000a55a/0", rd, e); end
    checks++;
    if ({tdm2p_en, tdm2p_clk_mask, tdm2p_clk_patt} !== 17'h1A55A) begin
      errors++; $display("FAIL ctrl_outs got %h exp 1a55a", {tdm2p_en, tdm2p_clk_mask, tdm2p_clk_patt});
    end
    checks++;
  endtask

  task automatic test_snapshot;
    logic [31:0] rd; logic e;
    for (int k = 0; k < 8; k++) tdm2p_pdata[k*32 +: 32] = 32'hA000_0000 + k;
    bus(10'h010, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'hA000_0000) begin errors++; $display("FAIL snap_w0 got %h exp a0000000", rd); end
    checks++;
    for (int k = 0; k < 8; k++) tdm2p_pdata[k*32 +: 32] = 32'hB000_0000 + k;
    bus(10'h014, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'hA000_0001 || e !== 1'b0) begin errors++; $display("FAIL snap_w1 got %h/%b exp a0000001/0", rd, e); end
    checks++;
    bus(10'h02C, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'hA000_0007) begin errors++; $display("FAIL snap_w7 got %h exp a0000007", rd); end
    checks++;
  endtask

  task automatic test_frame_status;
    logic [31:0] rd; logic e;
    bus(10'h000, 1'b1, 32'h4000_0000, 1'b0, rd, e);
    repeat (2) begin
      @(negedge clk); tdm2p_valid = 1'b1;
      @(negedge clk); tdm2p_valid = 1'b0;
    end
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
    checks++;
    bus(10'h004, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'h3) begin errors++; $display("FAIL status_3 got %h exp 3", rd); end
    checks++;
    bus(10'h004, 1'b1, 32'h2, 1'b0, rd, e);
    bus(10'h004, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'h1) begin errors++; $display("FAIL status_w1c got %h exp 1", rd); end
    checks++;
    bus(10'h010, 1'b0, 32'h0, 1'b0, rd, e);
    bus(10'h004, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'h0) begin errors++; $display("FAIL status_clr got %h exp 0", rd); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr got %b exp 0", irq); end
    checks++;
  endtask

  task automatic test_counters;
    logic [31:0] rd; logic e;
    @(negedge clk); p2tdm_retrans_incr = 1'b1;
    repeat (32'h10004) @(negedge clk);
    bus(10'h104, 1'b0, 32'h0, 1'b1, rd, e);
    if (rd !== 32'hFFFF_0000) begin errors++; $display("FAIL retrans_sat got %h exp ffff0000", rd); end
    checks++;
    bus(10'h104, 1'b1, 32'h0, 1'b1, rd, e);
    bus(10'h104, 1'b0, 32'h0, 1'b1, rd, e);
    if (rd !== 32'h0) begin errors++; $display("FAIL write_beats_incr got %h exp 0", rd); end
    checks++;
    bus(10'h104, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'h0001_0000) begin errors++; $display("FAIL read_incr_next got %h exp 00010000", rd); end
    checks++;
    bus(10'h104, 1'b1, 32'h0000_FFFE, 1'b0, rd, e);
    repeat (3) begin
      @(negedge clk); p2tdm_dropped_incr = 1'b1;
      @(negedge clk); p2tdm_dropped_incr = 1'b0;
    end
    bus(10'h104, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'h0000_FFFF) begin errors++; $display("FAIL dropped_sat got %h exp 0000ffff", rd); end
    checks++;
`ifdef CSR_CLR_ON_READ_EN
    bus(10'h104, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'h0) begin errors++; $display("FAIL clr_on_read got %h exp 0", rd); end
    checks++;
`endif
  endtask

  task automatic test_p2tdm_commit;
    logic [31:0] rd; logic e;
    logic [PDATA_W-1:0] exp_pkt;
    for (int k = 0; k < 8; k++) exp_pkt[k*32 +: 32] = 32'h5A00_0000 + 32'(k * 32'h0101);
    pulses = 0;
    pulse_with_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus(10'(10'h110 + 4*k), 1'b1, exp_pkt[k*32 +: 32], 1'b0, rd, e);
      if (k < 7 && pulses !== 0) begin errors++; $display("FAIL early_commit word=%0d pulses=%0d exp 0", k, pulses); end
      if (k < 7) checks++;
    end
    repeat (3) @(negedge clk);
    if (pulses !== 1) begin errors++; $display("FAIL commit_count got %0d exp 1", pulses); end
    checks++;
    if (pulse_with_ready !== 1'b1) begin errors++; $display("FAIL commit_timing got %b exp 1", pulse_with_ready); end
    checks++;
    if (pkt_seen !== exp_pkt) begin errors++; $display("FAIL commit_pkt got %h exp %h", pkt_seen, exp_pkt); end
    checks++;
    bus(10'h11C, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'h5A00_0303 || e !== 1'b0) begin errors++; $display("FAIL pkt_rd got %h/%b exp 5a000303/0", rd, e); end
    checks++;
  endtask

  task automatic test_gain_bal;
    logic [31:0] rd; logic e;
    bus(10'h21C, 1'b1, 32'hFFAB_1234, 1'b0, rd, e);
    bus(10'h21C, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'h00AB_1234 || e !== 1'b0) begin errors++; $display("FAIL gain7_rd got %h/%b exp 00ab1234/0", rd, e); end
    checks++;
    if (gain[7*16 +: 16] !== 16'h1234 || bal[7*8 +: 8] !== 8'hAB || gain[6*16 +: 16] !== 16'h0) begin
      errors++; $display("FAIL gain7_out got %h/%h exp 1234/ab", gain[7*16 +: 16], bal[7*8 +: 8]);
    end
    checks++;
    bus(10'h220, 1'b0, 32'h0, 1'b0, rd, e);
    if (rd !== 32'hBADACE55 || e !== 1'b1) begin errors++; $display("FAIL gain8_unmapped got %h/%b exp badace55/1", rd, e); end
    checks++;
    bus(10'h300, 1'b1, 32'h1, 1'b0, rd, e);
    if (sel !== 1'b1) begin errors++; $display("FAIL sel got %b exp 1", sel); end
    checks++;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    val = 1'b1; addr = 10'h000; write = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    if (ready !== 1'b0 || sel !== 1'b0) begin errors++; $display("FAIL reset_mid got ready=%b sel=%b exp 0/0", ready, sel); end
    checks++;
    val = 1'b0;
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_mid_idle got %b exp 0", ready); end
    checks++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    test_reset;
    test_unmapped;
    test_snapshot;
    test_frame_status;
    test_counters;
    test_p2tdm_commit;
    test_gain_bal;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
